// File: rtl/spike_rate_decoder.sv
// Rate and inter-spike-interval decoder for a LIF spike train.
// Counts spikes over a programmable window and measures the most recent ISI.
module spike_rate_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [CNT_W-1:0] win_len,
    input  logic             ready,
    output logic [CNT_W-1:0] rate,
    output logic             valid,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid,
    output logic             ovf
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] isi_cnt;
    logic [CNT_W-1:0] win_len_q;
    logic             seen_spike;

    logic [CNT_W-1:0] win_last;
    logic [CNT_W-1:0] spk_next;
    logic [CNT_W-1:0] isi_inc;
    logic             win_close;
    logic             xfer;

    // A latched length of 0 wraps to all-ones, giving a 2^CNT_W cycle window.
    assign win_last  = win_len_q - CntOne;
    assign win_close = (state == StRun) && (win_cnt == win_last);
    assign spk_next  = (spike && (spk_cnt != CntMax)) ? spk_cnt + CntOne : spk_cnt;
    assign isi_inc   = (isi_cnt != CntMax) ? isi_cnt + CntOne : isi_cnt;
    assign xfer      = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            isi_cnt    <= '0;
            win_len_q  <= '0;
            seen_spike <= 1'b0;
            rate       <= '0;
            valid      <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            // Consumer handshake runs in both states; a window close below may re-raise valid.
            if (xfer) begin
                valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                    isi_cnt    <= '0;
                    seen_spike <= 1'b0;
                    ovf        <= 1'b0;
                    if (en) begin
                        state     <= StRun;
                        win_len_q <= win_len;
                    end
                end

                StRun: begin
                    if (win_close) begin
                        if (!valid || ready) begin
                            rate  <= spk_next;
                            valid <= 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        win_cnt   <= '0;
                        spk_cnt   <= '0;
                        win_len_q <= win_len;
                    end else begin
                        win_cnt <= win_cnt + CntOne;
                        spk_cnt <= spk_next;
                    end

                    if (spike) begin
                        isi_cnt    <= CntOne;
                        seen_spike <= 1'b1;
                        if (seen_spike) begin
                            isi       <= isi_cnt;
                            isi_valid <= 1'b1;
                        end
                    end else begin
                        isi_cnt <= isi_inc;
                    end

                    // Leaving RUN discards partial window and ISI history.
                    if (!en) begin
                        state      <= StIdle;
                        win_cnt    <= '0;
                        spk_cnt    <= '0;
                        isi_cnt    <= '0;
                        seen_spike <= 1'b0;
                        ovf        <= 1'b0;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: an event-level model predicts outputs each
// cycle and every delivered rate; a monitor compares against the DUT.
module tb_spike_rate_decoder;

    localparam int unsigned CNT_W = 8;
    localparam int MAXV = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             spike = 1'b0;
    logic [CNT_W-1:0] win_len = '0;
    logic             ready = 1'b0;
    logic [CNT_W-1:0] rate;
    logic             valid;
    logic [CNT_W-1:0] isi;
    logic             isi_valid;
    logic             ovf;

    spike_rate_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spike     (spike),
        .win_len   (win_len),
        .ready     (ready),
        .rate      (rate),
        .valid     (valid),
        .isi       (isi),
        .isi_valid (isi_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Reference model: absolute cycle indices and plain integer counts.
    bit m_run, m_has_last;
    int m_now, m_wstart, m_len, m_wspk, m_last;
    int e_rate, e_isi;
    bit e_valid, e_isi_valid, e_ovf;
    bit m_xfer, m_nv;
    logic [31:0] exp_q[$];
    int xfer_q[$];

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic int eff_len(input logic [CNT_W-1:0] w);
        return (w == 0) ? (1 << CNT_W) : int'(w);
    endfunction

    function automatic logic [31:0] pack_exp();
        return {13'd0, CNT_W'(e_rate), e_valid, CNT_W'(e_isi), e_isi_valid, e_ovf};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_has_last = 0; m_now = 0; m_wstart = 0; m_len = 0; m_wspk = 0;
            m_last = 0; e_rate = 0; e_isi = 0; e_valid = 0; e_isi_valid = 0; e_ovf = 0;
            xfer_q.delete();
        end else begin
            m_xfer = e_valid && ready;
            m_nv   = e_valid && !m_xfer;
            if (!m_run) begin
                e_ovf = 0;
                if (en) begin
                    m_run = 1; m_now = 0; m_wstart = 0; m_wspk = 0; m_has_last = 0;
                    m_len = eff_len(win_len);
                end
            end else begin
                if (spike) m_wspk++;
                if (m_now - m_wstart == m_len - 1) begin
                    if (!e_valid || ready) begin
                        e_rate = sat(m_wspk);
                        m_nv = 1;
                        xfer_q.push_back(e_rate);
                    end else begin
                        e_ovf = 1;
                    end
                    m_wstart = m_now + 1;
                    m_len = eff_len(win_len);
                    m_wspk = 0;
                end
                if (spike) begin
                    if (m_has_last) begin
                        e_isi = sat(m_now - m_last);
                        e_isi_valid = 1;
                    end
                    m_has_last = 1;
                    m_last = m_now;
                end
                m_now++;
                if (!en) begin
                    m_run = 0;
                    e_ovf = 0;
                end
            end
            e_valid = m_nv;
        end
        exp_q.push_back(pack_exp());
    end

    // Monitor: per-cycle output check plus a check of every delivered rate.
    logic             prev_valid = 1'b0;
    logic [CNT_W-1:0] prev_rate = '0;
    logic [31:0]      act_w, exp_w;
    int               exp_rate;

    always @(posedge clk) begin
        #1;
        act_w = {13'd0, rate, valid, isi, isi_valid, ovf};
        if (exp_q.size() == 0) begin
            chk(1'b0, "outputs_no_expectation", act_w, 32'hffff_ffff);
        end else begin
            exp_w = exp_q.pop_front();
            chk(act_w == exp_w, "outputs{rate,valid,isi,isi_valid,ovf}", act_w, exp_w);
        end
        if (rst_n && prev_valid && ready) begin
            if (xfer_q.size() == 0) begin
                chk(1'b0, "unexpected_transfer", 32'(prev_rate), 32'hffff_ffff);
            end else begin
                exp_rate = xfer_q.pop_front();
                chk(32'(prev_rate) == 32'(exp_rate), "transferred_rate",
                    32'(prev_rate), 32'(exp_rate));
            end
        end
        prev_valid = rst_n ? valid : 1'b0;
        prev_rate  = rate;
    end

    task automatic drive(input bit e, input bit s, input bit r, input logic [CNT_W-1:0] w);
        @(negedge clk);
        en = e; spike = s; ready = r; win_len = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CNT_W-1:0] w;
        // Reset held across edges.
        repeat (2) @(negedge clk);
        chk({rate, valid, isi, isi_valid, ovf} == '0, "reset_outputs",
            32'({rate, valid, isi, isi_valid, ovf}), 32'd0);
        rst_n = 1'b1;

        // Window of 10 with spikes on window cycles 0, 3, 9.
        drive(1, 0, 1, 10);
        for (int k = 0; k < 10; k++) drive(1, (k == 0) || (k == 3) || (k == 9), 1, 10);
        repeat (3) drive(1, 0, 1, 10);
        repeat (2) drive(0, 0, 1, 10);

        // Continuous spiking: short windows, then a full 256-cycle window saturating.
        drive(1, 0, 1, 4);
        repeat (16) drive(1, 1, 1, 4);
        repeat (2) drive(0, 0, 1, 4);
        drive(1, 0, 1, 0);
        repeat (520) drive(1, 1, 1, 0);
        repeat (2) drive(0, 0, 1, 0);

        // Overflow: two closes without ready, one accept, then leave RUN.
        drive(1, 0, 0, 5);
        repeat (10) drive(1, 1, 0, 5);
        drive(1, 0, 1, 5);
        repeat (2) drive(1, 0, 0, 5);
        repeat (2) drive(0, 0, 0, 5);

        // ISI: spikes at t, t+1, t+7, then a 300-cycle gap.
        drive(1, 0, 1, 0);
        repeat (3) drive(1, 0, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        repeat (5) drive(1, 0, 1, 0);
        drive(1, 1, 1, 0);
        repeat (299) drive(1, 0, 1, 0);
        drive(1, 1, 1, 0);
        repeat (2) drive(1, 0, 1, 0);
        repeat (2) drive(0, 0, 1, 0);

        // win_len change mid-window only applies to the next window.
        drive(1, 0, 1, 8);
        repeat (3) drive(1, 1'($urandom_range(0, 1)), 1, 8);
        repeat (12) drive(1, 1'($urandom_range(0, 1)), 1, 3);
        repeat (2) drive(0, 0, 1, 3);

        // Asynchronous reset mid-window while a result is pending.
        drive(1, 0, 0, 2);
        repeat (5) drive(1, 1, 0, 2);
        drive(1, 1, 0, 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk({rate, valid, isi, isi_valid, ovf} == '0, "async_reset_outputs",
               32'({rate, valid, isi, isi_valid, ovf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) drive(1, 1, 1, 4);
        repeat (2) drive(0, 0, 1, 4);

        // Randomized traffic.
        w = 6;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) w = CNT_W'($urandom_range(0, 9));
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)), w);
        end
        repeat (3) drive(0, 0, 1, w);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
